// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // A request is in error when its size is illegal or its offset breaks natural alignment.
    function automatic logic access_err(size_t sz, logic [1:0] off);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges store data into the old word and extracts/extends load data.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_word_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o,
    output logic        err_o
);

    size_t      size;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;

    assign size     = size_t'(size_i);
    assign err_o    = access_err(size, off_i);
    assign byte_sel = old_word_i[{off_i, 3'b000} +: 8];
    assign half_sel = old_word_i[{off_i[1], 4'b0000} +: 16];

    // Store merge: only the addressed lanes take new data.
    always_comb begin
        merged_o = old_word_i;
        case (size)
            SZ_B:    merged_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
            SZ_H:    merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            SZ_W:    merged_o = wdata_i;
            default: merged_o = old_word_i;
        endcase
    end

    // Load extract with zero/sign extension; word loads ignore the unsigned flag.
    always_comb begin
        load_o = '0;
        case (size)
            SZ_B:    load_o = unsigned_i ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    load_o = unsigned_i ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            SZ_W:    load_o = old_word_i;
            default: load_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, fixed latency, held response out.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 1024,
    parameter int LATENCY       = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [1:0]               req_size_i,
    input  logic                     req_unsigned_i,
    input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0]    req_wdata_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
    output logic                     rsp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, uns_q;
    logic [1:0]              size_q;
    logic [IDX_W+1:0]        addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    accept, access, mem_we;
    logic                    src_we, src_uns;
    logic [1:0]              src_size;
    logic [IDX_W+1:0]        src_addr;
    logic [DATA_WIDTH-1:0]   src_wdata;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   old_word, merged, load_word;
    logic                    lane_err;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign accept      = req_valid_i && req_ready_o;

    // High address bits are deliberately dropped so the array aliases modulo its size.
    if (ADDRESS_WIDTH > IDX_W + 2) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr_i[ADDRESS_WIDTH-1:IDX_W+2];
    end

    // With single-cycle latency the access happens on the acceptance edge, so the
    // live request feeds the datapath in IDLE; otherwise the captured copy does.
    assign src_we    = (state_q == IDLE) ? req_we_i                  : we_q;
    assign src_size  = (state_q == IDLE) ? req_size_i                : size_q;
    assign src_uns   = (state_q == IDLE) ? req_unsigned_i            : uns_q;
    assign src_addr  = (state_q == IDLE) ? req_addr_i[IDX_W+1:0]     : addr_q;
    assign src_wdata = (state_q == IDLE) ? req_wdata_i               : wdata_q;

    assign idx      = src_addr[IDX_W+1:2];
    assign old_word = mem_q[idx];

    dmem_lane_align u_align (
        .size_i     (src_size),
        .off_i      (src_addr[1:0]),
        .unsigned_i (src_uns),
        .wdata_i    (src_wdata),
        .old_word_i (old_word),
        .merged_o   (merged),
        .load_o     (load_word),
        .err_o      (lane_err)
    );

    // Reset gates the write so an edge seen while reset is held can never commit a store.
    assign mem_we = access && src_we && !lane_err && rst_ni;

    // FSM next state, latency countdown and response data on the RESP entry edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = CNT_LOAD;
                    if (CNT_LOAD == '0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (access) begin
            err_d   = lane_err;
            rdata_d = (src_we || lane_err) ? '0 : load_word;
        end
    end

    // State, counter and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request capture at acceptance only; later input changes are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i[IDX_W+1:0];
            wdata_q <= req_wdata_i;
        end
    end

    // Storage array; not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder against a byte-addressed reference memory.
module tb_dmem_responder;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int   tests = 0;
    int   fails = 0;
    int   rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled
    exp_t q[$];
    logic [7:0] ref_mem [4096];

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDRESS_WIDTH (16),
        .DATA_WIDTH    (32),
        .DEPTH_WORDS   (1024),
        .LATENCY       (LAT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: memory is a flat byte array; an access touches 2**size bytes.
    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [15:0] addr, input logic [31:0] wd);
        exp_t        e;
        int          n;
        int          a;
        logic [31:0] v;
        a = int'(addr[11:0]);
        n = 1 << sz;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        if (sz == 2'b11 || (a % n) != 0) begin
            e.err = 1'b1;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic drive_req(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [15:0] addr, input logic [31:0] wd);
        int guard = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: req_ready stuck at %b", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = 16'($urandom);
        req_wdata    = $urandom;
    endtask

    task automatic wait_rsp();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 20);
        chk("latency", 32'(k), 32'(LAT));
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wd);
        q.push_back(model(we, sz, uns, addr, wd));
        drive_req(we, sz, uns, addr, wd);
        wait_rsp();
    endtask

    task automatic issue_k(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [15:0] addr, input logic [31:0] wd,
                           input logic [31:0] k_rd, input logic k_err);
        exp_t e;
        e = model(we, sz, uns, addr, wd);
        e.rdata = k_rd;
        e.err   = k_err;
        q.push_back(e);
        drive_req(we, sz, uns, addr, wd);
        wait_rsp();
    endtask

    // Monitor: drives rsp_ready, checks hold stability and pops the scoreboard on handshake.
    initial begin
        logic        held;
        logic [31:0] h_rd;
        logic        h_err;
        exp_t        e;
        held = 1'b0;
        h_rd = 32'h0;
        h_err = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       rsp_ready = ($urandom_range(0, 3) != 0);
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'b0;
            endcase
            if (!rst_n || !rsp_valid) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_rdata", rsp_rdata, h_rd);
                    chk("hold_err", 32'(rsp_err), 32'(h_err));
                    chk("hold_req_ready", 32'(req_ready), 32'h0);
                end
                if (rsp_ready) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: rdata %h err %b with empty scoreboard",
                                 rsp_rdata, rsp_err);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                    held = 1'b0;
                end else begin
                    held  = 1'b1;
                    h_rd  = rsp_rdata;
                    h_err = rsp_err;
                end
            end
        end
    end

    initial begin
        logic [31:0] s_rd;
        logic        s_err;
        int          guard;

        // Reset values while held in reset.
        #2;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h1);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Give the region used below defined contents.
        rdy_mode = 1;
        for (int w = 0; w < 16; w++) issue(1'b1, 2'b10, 1'b0, 16'(w * 4), $urandom);

        // Word store/load.
        issue_k(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue_k(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Lane handling.
        issue_k(1'b1, 2'b00, 1'b0, 16'h0012, 32'h0000_007F, 32'h0, 1'b0);
        issue_k(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hDE7F_BEEF, 1'b0);
        issue_k(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, 32'hFFFF_FFDE, 1'b0);
        issue_k(1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, 32'h0000_00DE, 1'b0);
        issue_k(1'b0, 2'b01, 1'b1, 16'h0010, 32'h0, 32'h0000_BEEF, 1'b0);

        // Misaligned and illegal requests.
        issue_k(1'b1, 2'b10, 1'b0, 16'h0011, 32'h0000_0001, 32'h0, 1'b1);
        issue_k(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hDE7F_BEEF, 1'b0);
        issue_k(1'b0, 2'b01, 1'b0, 16'h0013, 32'h0, 32'h0, 1'b1);
        issue_k(1'b0, 2'b11, 1'b0, 16'h0010, 32'h0, 32'h0, 1'b1);
        issue_k(1'b1, 2'b11, 1'b0, 16'h0010, 32'h1234_5678, 32'h0, 1'b1);

        // Backpressure: response must hold for 5 stalled cycles.
        rdy_mode = 2;
        issue_k(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hDE7F_BEEF, 1'b0);
        s_rd  = rsp_rdata;
        s_err = rsp_err;
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rdata", rsp_rdata, s_rd);
            chk("bp_err", 32'(rsp_err), 32'(s_err));
            chk("bp_req_ready", 32'(req_ready), 32'h0);
        end
        rdy_mode = 1;

        // Reset during WAIT aborts the store.
        drive_req(1'b1, 2'b10, 1'b0, 16'h0010, 32'h1234_5678);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_wait_req_ready", 32'(req_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue_k(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hDE7F_BEEF, 1'b0);

        // Reset during RESP drops the response at once.
        rdy_mode = 2;
        drive_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
        wait_rsp();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_resp_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_resp_req_ready", 32'(req_ready), 32'h1);
        chk("rst_resp_rdata", rsp_rdata, 32'h0);
        chk("rst_resp_err", 32'(rsp_err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;

        // Address wrap modulo array size.
        issue_k(1'b1, 2'b10, 1'b0, 16'h1010, 32'h0000_00A5, 32'h0, 1'b0);
        issue_k(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'h0000_00A5, 1'b0);

        // Randomised traffic with random backpressure.
        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom),
                  16'(($urandom_range(0, 15) << 12) | $urandom_range(0, 63)), $urandom);
        end

        rdy_mode = 1;
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
